// File: rtl/dmem_arbiter_if.sv
// Bundled master-port, memory-port and response signals of the data-memory arbiter.
// The slave modport is the arbiter's view. The master modport is the view of the masters and the memory.
interface dmem_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  m0_req;
    logic                  m0_we;
    logic [DATA_WIDTH-1:0] m0_addr;
    logic [DATA_WIDTH-1:0] m0_wdata;
    logic                  m0_gnt;
    logic                  m0_rvalid;
    logic [DATA_WIDTH-1:0] m0_rdata;
    logic                  m0_err;

    logic                  m1_req;
    logic                  m1_we;
    logic [DATA_WIDTH-1:0] m1_addr;
    logic [DATA_WIDTH-1:0] m1_wdata;
    logic                  m1_gnt;
    logic                  m1_rvalid;
    logic [DATA_WIDTH-1:0] m1_rdata;
    logic                  m1_err;

    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_a;
    logic [DATA_WIDTH-1:0] mem_wd;
    logic [DATA_WIDTH-1:0] mem_rd;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_gnt, m0_rvalid, m0_rdata, m0_err,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m1_gnt, m1_rvalid, m1_rdata, m1_err,
        output mem_we, mem_a, mem_wd,
        input  mem_rd
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_gnt, m0_rvalid, m0_rdata, m0_err,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m1_gnt, m1_rvalid, m1_rdata, m1_err,
        input  mem_we, mem_a, mem_wd,
        output mem_rd
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and single-access sequencer in front of the data memory.
// Optional feature: define DMEM_ARB_ALIGN_CHECK_EN to reject and flag word-misaligned accesses.
module dmem_arbiter #(
    parameter int unsigned DATA_WIDTH        = 32,
    parameter int unsigned RAM_ADDRESS_WIDTH = 18
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } state_t;

    if (RAM_ADDRESS_WIDTH < 3 || RAM_ADDRESS_WIDTH > DATA_WIDTH) begin : g_bad_cfg
        $error("dmem_arbiter: RAM_ADDRESS_WIDTH out of range");
    end

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_last_grant;   // 1: M1 was granted most recently
    logic                  r_cap_port;
    logic                  r_cap_we;
    logic                  r_cap_err;
    logic [DATA_WIDTH-1:0] r_mem_a;
    logic [DATA_WIDTH-1:0] r_mem_wd;
    logic                  r_m0_rvalid;
    logic                  r_m1_rvalid;
    logic                  r_m0_err;
    logic                  r_m1_err;
    logic [DATA_WIDTH-1:0] r_m0_rdata;
    logic [DATA_WIDTH-1:0] r_m1_rdata;

    logic                  w_arb_en;
    logic                  w_gnt0;
    logic                  w_gnt1;
    logic                  w_any_gnt;
    logic                  w_sel_we;
    logic [DATA_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;
    logic                  w_misalign;
    logic [DATA_WIDTH-1:0] w_rsp_data;

`ifdef DMEM_ARB_ALIGN_CHECK_EN
    assign w_misalign = (w_sel_addr[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    always_comb begin
        w_arb_en    = !rst && (r_state == ST_IDLE || r_state == ST_RESP);
        w_gnt0      = w_arb_en && bus.m0_req && (!bus.m1_req || r_last_grant);
        w_gnt1      = w_arb_en && bus.m1_req && (!bus.m0_req || !r_last_grant);
        w_any_gnt   = w_gnt0 || w_gnt1;
        w_sel_we    = w_gnt1 ? bus.m1_we    : bus.m0_we;
        w_sel_addr  = w_gnt1 ? bus.m1_addr  : bus.m0_addr;
        w_sel_wdata = w_gnt1 ? bus.m1_wdata : bus.m0_wdata;
        w_rsp_data  = (r_cap_we || r_cap_err) ? '0 : bus.mem_rd;

        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_any_gnt) w_state_nxt = ST_ACCESS;
            ST_ACCESS: w_state_nxt = ST_RESP;
            ST_RESP:   w_state_nxt = w_any_gnt ? ST_ACCESS : ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_cap_port   <= 1'b0;
            r_cap_we     <= 1'b0;
            r_cap_err    <= 1'b0;
            r_mem_a      <= '0;
            r_mem_wd     <= '0;
            r_m0_rvalid  <= 1'b0;
            r_m1_rvalid  <= 1'b0;
            r_m0_err     <= 1'b0;
            r_m1_err     <= 1'b0;
            r_m0_rdata   <= '0;
            r_m1_rdata   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_any_gnt) begin
                r_last_grant <= w_gnt1;
                r_cap_port   <= w_gnt1;
                r_cap_we     <= w_sel_we;
                r_cap_err    <= w_misalign;
                r_mem_a      <= w_sel_addr;
                r_mem_wd     <= w_sel_wdata;
            end
            // Response registers load only at the end of ACCESS, so they pulse for exactly the RESP cycle
            if (r_state == ST_ACCESS) begin
                r_m0_rvalid <= !r_cap_port;
                r_m1_rvalid <= r_cap_port;
                r_m0_err    <= !r_cap_port && r_cap_err;
                r_m1_err    <= r_cap_port && r_cap_err;
                r_m0_rdata  <= r_cap_port ? '0 : w_rsp_data;
                r_m1_rdata  <= r_cap_port ? w_rsp_data : '0;
            end else begin
                r_m0_rvalid <= 1'b0;
                r_m1_rvalid <= 1'b0;
                r_m0_err    <= 1'b0;
                r_m1_err    <= 1'b0;
                r_m0_rdata  <= '0;
                r_m1_rdata  <= '0;
            end
        end
    end

    assign bus.m0_gnt    = w_gnt0;
    assign bus.m1_gnt    = w_gnt1;
    assign bus.m0_rvalid = r_m0_rvalid;
    assign bus.m1_rvalid = r_m1_rvalid;
    assign bus.m0_err    = r_m0_err;
    assign bus.m1_err    = r_m1_err;
    assign bus.m0_rdata  = r_m0_rdata;
    assign bus.m1_rdata  = r_m1_rdata;
    assign bus.mem_a     = r_mem_a;
    assign bus.mem_wd    = r_mem_wd;
    // Reset gates the write strobe in the same cycle so an interrupted write never commits
    assign bus.mem_we    = (r_state == ST_ACCESS) && r_cap_we && !r_cap_err && !rst;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter with a behavioural word memory on the memory port.
module tb_dmem_arbiter;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    int   we_cnt;
    int   we_before;

    logic [31:0] mem [0:255] = '{4: 32'hDEAD_BEEF, 8: 32'h0000_0000, 16: 32'h5555_5555, default: 32'h0};

    dmem_arbiter_if #(.DATA_WIDTH(32)) bus ();

    dmem_arbiter #(.DATA_WIDTH(32), .RAM_ADDRESS_WIDTH(18)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.mem_rd = mem[bus.mem_a[9:2]];

    always @(posedge clk) begin
        if (bus.mem_we) begin
            mem[bus.mem_a[9:2]] <= bus.mem_wd;
            we_cnt <= we_cnt + 1;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic smp;
        @(negedge clk);
    endtask

    initial begin
        n_vec = 0; n_err = 0; we_cnt = 0;
        rst = 1'b1;
        bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'h10; bus.m0_wdata = '0;
        bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = '0;     bus.m1_wdata = '0;

        // Reset state, with a pending request that must not be granted
        smp;
        chk("rst_m0_gnt", 32'(bus.m0_gnt), 0);
        chk("rst_m1_gnt", 32'(bus.m1_gnt), 0);
        chk("rst_m0_rvalid", 32'(bus.m0_rvalid), 0);
        chk("rst_m1_rvalid", 32'(bus.m1_rvalid), 0);
        chk("rst_errs", {30'b0, bus.m0_err, bus.m1_err}, 0);
        chk("rst_m0_rdata", bus.m0_rdata, 0);
        chk("rst_m1_rdata", bus.m1_rdata, 0);
        chk("rst_mem_we", 32'(bus.mem_we), 0);
        chk("rst_mem_a", bus.mem_a, 0);
        chk("rst_mem_wd", bus.mem_wd, 0);
        nxt; nxt;
        rst = 1'b0;

        // M0 read of 0x10
        smp;
        chk("t1_m0_gnt", 32'(bus.m0_gnt), 1);
        chk("t1_m1_gnt", 32'(bus.m1_gnt), 0);
        nxt; bus.m0_req = 1'b0;
        smp;
        chk("t1_acc_mem_we", 32'(bus.mem_we), 0);
        chk("t1_acc_mem_a", bus.mem_a, 32'h10);
        chk("t1_acc_gnt", 32'(bus.m0_gnt), 0);
        nxt; smp;
        chk("t1_m0_rvalid", 32'(bus.m0_rvalid), 1);
        chk("t1_m0_rdata", bus.m0_rdata, 32'hDEAD_BEEF);
        chk("t1_m0_err", 32'(bus.m0_err), 0);
        chk("t1_m1_rvalid", 32'(bus.m1_rvalid), 0);
        nxt;

        // M1 write then read-back of 0x20
        we_before = we_cnt;
        bus.m1_req = 1'b1; bus.m1_we = 1'b1; bus.m1_addr = 32'h20; bus.m1_wdata = 32'h1234_5678;
        smp;
        chk("t2_m1_gnt", 32'(bus.m1_gnt), 1);
        chk("t2_m0_gnt", 32'(bus.m0_gnt), 0);
        nxt; bus.m1_we = 1'b0;
        smp;
        chk("t2_wr_mem_we", 32'(bus.mem_we), 1);
        chk("t2_wr_mem_a", bus.mem_a, 32'h20);
        chk("t2_wr_mem_wd", bus.mem_wd, 32'h1234_5678);
        chk("t2_acc_m1_gnt", 32'(bus.m1_gnt), 0);
        nxt; smp;
        chk("t2_wr_m1_rvalid", 32'(bus.m1_rvalid), 1);
        chk("t2_wr_m1_rdata", bus.m1_rdata, 0);
        chk("t2_wr_m0_rvalid", 32'(bus.m0_rvalid), 0);
        chk("t2_rd_m1_gnt", 32'(bus.m1_gnt), 1);
        nxt; bus.m1_req = 1'b0;
        smp;
        chk("t2_rd_mem_we", 32'(bus.mem_we), 0);
        chk("t2_rd_mem_a", bus.mem_a, 32'h20);
        nxt; smp;
        chk("t2_rd_m1_rvalid", 32'(bus.m1_rvalid), 1);
        chk("t2_rd_m1_rdata", bus.m1_rdata, 32'h1234_5678);
        chk("t2_mem_word20", mem[8], 32'h1234_5678);
        chk("t2_we_cycles", 32'(we_cnt - we_before), 1);
        nxt;

        // Both ports read continuously: alternate starting with M0
        bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'h10;
        bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 32'h20;
        for (int i = 0; i < 8; i++) begin
            smp;
            chk($sformatf("t3_g%0d_m0_gnt", i), 32'(bus.m0_gnt), 32'((i % 2) == 0));
            chk($sformatf("t3_g%0d_m1_gnt", i), 32'(bus.m1_gnt), 32'((i % 2) == 1));
            if (i > 0) begin
                chk($sformatf("t3_r%0d_m0_rvalid", i), 32'(bus.m0_rvalid), 32'((i % 2) == 1));
                chk($sformatf("t3_r%0d_m1_rvalid", i), 32'(bus.m1_rvalid), 32'((i % 2) == 0));
                if ((i % 2) == 1) chk($sformatf("t3_r%0d_m0_rdata", i), bus.m0_rdata, 32'hDEAD_BEEF);
                else              chk($sformatf("t3_r%0d_m1_rdata", i), bus.m1_rdata, 32'h1234_5678);
            end
            nxt; smp;
            chk($sformatf("t3_a%0d_gnt", i), {30'b0, bus.m0_gnt, bus.m1_gnt}, 0);
            chk($sformatf("t3_a%0d_rvalid", i), {30'b0, bus.m0_rvalid, bus.m1_rvalid}, 0);
            nxt;
        end
        bus.m0_req = 1'b0; bus.m1_req = 1'b0;
        smp;
        chk("t3_last_m1_rvalid", 32'(bus.m1_rvalid), 1);
        chk("t3_last_m1_rdata", bus.m1_rdata, 32'h1234_5678);
        chk("t3_last_m0_rvalid", 32'(bus.m0_rvalid), 0);
        nxt;

        // Reset during the ACCESS of an M0 write
        bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = 32'h40; bus.m0_wdata = 32'hAAAA_AAAA;
        smp;
        chk("t4_m0_gnt", 32'(bus.m0_gnt), 1);
        nxt; bus.m0_req = 1'b0; rst = 1'b1;
        smp;
        chk("t4_rst_mem_we", 32'(bus.mem_we), 0);
        nxt; rst = 1'b0;
        bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'h10;
        bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 32'h20;
        smp;
        chk("t4_no_m0_rvalid", 32'(bus.m0_rvalid), 0);
        chk("t4_mem_word40", mem[16], 32'h5555_5555);
        chk("t4_tie_m0_gnt", 32'(bus.m0_gnt), 1);
        chk("t4_tie_m1_gnt", 32'(bus.m1_gnt), 0);
        nxt; bus.m0_req = 1'b0; bus.m1_req = 1'b0;
        nxt; smp;
        chk("t4_m0_rvalid", 32'(bus.m0_rvalid), 1);
        chk("t4_m0_rdata", bus.m0_rdata, 32'hDEAD_BEEF);
        nxt;

        // Misaligned M0 write to 0x42
        bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = 32'h42; bus.m0_wdata = 32'hCAFE_F00D;
        smp;
        chk("t5_m0_gnt", 32'(bus.m0_gnt), 1);
        nxt; bus.m0_req = 1'b0;
        smp;
        chk("t5_mem_we", 32'(bus.mem_we), ALIGN ? 32'd0 : 32'd1);
        chk("t5_mem_a", bus.mem_a, 32'h42);
        nxt; smp;
        chk("t5_m0_rvalid", 32'(bus.m0_rvalid), 1);
        chk("t5_m0_err", 32'(bus.m0_err), ALIGN ? 32'd1 : 32'd0);
        chk("t5_m0_rdata", bus.m0_rdata, 0);
        chk("t5_mem_word40", mem[16], ALIGN ? 32'h5555_5555 : 32'hCAFE_F00D);
        nxt;

        // M0 request withdrawn while M1 wins the tie
        bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'h10;
        bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 32'h20;
        smp;
        chk("t6_m1_gnt", 32'(bus.m1_gnt), 1);
        chk("t6_m0_gnt", 32'(bus.m0_gnt), 0);
        nxt; bus.m0_req = 1'b0; bus.m1_req = 1'b0;
        smp;
        chk("t6_acc_m0_gnt", 32'(bus.m0_gnt), 0);
        nxt; smp;
        chk("t6_m1_rvalid", 32'(bus.m1_rvalid), 1);
        chk("t6_m1_rdata", bus.m1_rdata, 32'h1234_5678);
        chk("t6_m0_rvalid", 32'(bus.m0_rvalid), 0);
        nxt; smp;
        chk("t6_idle_m0_gnt", 32'(bus.m0_gnt), 0);
        chk("t6_idle_m0_rvalid", 32'(bus.m0_rvalid), 0);
        chk("t6_idle_m1_rvalid", 32'(bus.m1_rvalid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
